// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to single APB3 transfers with wait-state timeout
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic term;
  assign req_ready = (state == IDLE) && !rst;
  assign term = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          paddr   <= req_addr;
          pwrite  <= req_write;
          pwdata  <= req_write ? req_wdata : pwdata;
          psel    <= 1'b1;
          penable <= 1'b0;
          state   <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // completion wins over a timeout landing on the same cycle
          if (pready || term) begin
            rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
            rsp_slverr  <= pready ? pslverr : 1'b1;
            rsp_timeout <= !pready;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed plus randomized checks of apb_cmd_master against a transaction-level model
module tb_apb_cmd_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic req_valid = 0, req_ready, req_write = 0, rsp_valid, rsp_ready = 0, rsp_slverr, rsp_timeout;
  logic [7:0] req_addr = 0, paddr;
  logic [31:0] req_wdata = 0, rsp_rdata, pwdata, prdata;
  logic pwrite, psel, penable, pready, pslverr;

  logic t_req_valid = 0, t_req_ready, t_req_write = 0, t_rsp_valid, t_rsp_ready = 0, t_rsp_slverr, t_rsp_timeout;
  logic [7:0] t_req_addr = 0, t_paddr;
  logic [31:0] t_req_wdata = 0, t_rsp_rdata, t_pwdata;
  logic t_pwrite, t_psel, t_penable;

  apb_cmd_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .paddr(paddr),
    .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  apb_cmd_master #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_addr(t_req_addr),
    .req_write(t_req_write), .req_wdata(t_req_wdata), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_rdata(t_rsp_rdata), .rsp_slverr(t_rsp_slverr), .rsp_timeout(t_rsp_timeout), .paddr(t_paddr),
    .pwrite(t_pwrite), .psel(t_psel), .penable(t_penable), .pwdata(t_pwdata), .prdata(32'h1234_5678),
    .pready(1'b0), .pslverr(1'b0)
  );

  // slave: s_waits ACCESS cycles with pready low, then completes
  logic [31:0] mem [256];
  int acnt = 0, s_waits = 0;
  logic s_err = 0;
  assign pready  = psel && penable && (acnt >= s_waits);
  assign prdata  = mem[paddr];
  assign pslverr = pready && s_err;
  always @(posedge clk) begin
    acnt <= (psel && penable && !pready) ? acnt + 1 : 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  // reference model: memory contents and the last data word put on the bus
  logic [31:0] refmem [256];
  logic [31:0] last_wd = 0;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) chk("penable_without_psel", {63'd0, penable && !psel}, 0);

  task automatic do_cmd(input logic [7:0] a, input logic w, input logic [31:0] d,
                        input int waits, input logic e, input int dly);
    logic to;
    logic [31:0] er, ewd;
    int lat, k;
    to  = waits >= 16;
    ewd = w ? d : last_wd;
    er  = (to || w) ? 32'd0 : refmem[a];
    s_waits = waits;
    s_err = e;
    @(negedge clk);
    req_valid = 1; req_addr = a; req_write = w; req_wdata = d;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk("psel_held", psel, 1);
      chk("penable_phase", penable, lat > 1);
      chk("paddr_stable", paddr, a);
      chk("pwrite_stable", pwrite, w);
      chk("pwdata_stable", pwdata, ewd);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, to ? 18 : 3 + waits);
    chk("rsp_valid", rsp_valid, 1);
    chk("psel_done", psel, 0);
    chk("paddr_hold", paddr, a);
    chk("rsp_rdata", rsp_rdata, er);
    chk("rsp_slverr", rsp_slverr, to | e);
    chk("rsp_timeout", rsp_timeout, to);
    chk("req_ready_busy", req_ready, 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, er);
      chk("bp_rsp_slverr", rsp_slverr, to | e);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_consumed", rsp_valid, 0);
    chk("req_ready_again", req_ready, 1);
    if (w && !to) refmem[a] = d;
    if (w) last_wd = d;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; refmem[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready_rel", req_ready, 1);

    do_cmd(8'h10, 1, 32'hDEAD_BEEF, 0, 0, 0);
    do_cmd(8'h10, 0, 32'h0, 0, 0, 0);
    do_cmd(8'h3F, 1, 32'hA5A5_A5A5, 1, 0, 0);
    do_cmd(8'h3F, 0, 32'h0, 1, 0, 0);
    do_cmd(8'h3F, 1, 32'h0BAD_F00D, 5, 0, 0);
    do_cmd(8'h3F, 0, 32'h0, 15, 0, 0);
    do_cmd(8'h50, 1, 32'h1111_2222, 16, 0, 0);
    do_cmd(8'h50, 0, 32'h0, 0, 0, 0);
    do_cmd(8'h20, 1, 32'hCAFE_0020, 0, 0, 0);
    do_cmd(8'h20, 0, 32'h0, 1, 1, 3);

    for (int n = 0; n < 25; n++)
      do_cmd(8'($urandom_range(0, 7) * 8), 1'($urandom), $urandom, $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, $urandom_range(0, 2));

    s_waits = 10;
    @(negedge clk);
    req_valid = 1; req_addr = 8'h44; req_write = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("mid_access_penable", penable, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    rst = 0;
    last_wd = 0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    do_cmd(8'h10, 0, 32'h0, 1, 0, 0);

    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      t_req_valid = 1; t_req_addr = 8'($urandom); t_req_write = 1'(j); t_req_wdata = $urandom;
      chk("t_req_ready", t_req_ready, 1);
      @(negedge clk);
      t_req_valid = 0;
      lat = 1;
      while (!t_rsp_valid && lat < 40) begin
        chk("t_psel_held", t_psel, 1);
        @(negedge clk);
        lat++;
      end
      chk("t_latency", lat, 6);
      chk("t_psel_done", t_psel, 0);
      chk("t_penable_done", t_penable, 0);
      chk("t_rsp_rdata", t_rsp_rdata, 0);
      chk("t_rsp_slverr", t_rsp_slverr, 1);
      chk("t_rsp_timeout", t_rsp_timeout, 1);
      t_rsp_ready = 1;
      @(negedge clk);
      t_rsp_ready = 0;
      chk("t_rsp_consumed", t_rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
